// File: rtl/prefetch_issue_queue_if.sv
// Bundle of prefetch input, demand-miss snoop and memory request/response signals
// for prefetch_issue_queue.
interface prefetch_issue_queue_if;
  logic [31:0] pf_addr_i;
  logic        pf_valid_i;
  logic        dmd_miss_i;
  logic [31:0] dmd_addr_i;
  logic        mem_req_v_o;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_ready_i;
  logic        mem_resp_v_i;
  logic [3:0]  outst_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] dup_cnt_o;

  modport slave (
    input  pf_addr_i, pf_valid_i, dmd_miss_i, dmd_addr_i, mem_req_ready_i, mem_resp_v_i,
    output mem_req_v_o, mem_req_addr_o, outst_o, drop_cnt_o, dup_cnt_o
  );

  modport master (
    output pf_addr_i, pf_valid_i, dmd_miss_i, dmd_addr_i, mem_req_ready_i, mem_resp_v_i,
    input  mem_req_v_o, mem_req_addr_o, outst_o, drop_cnt_o, dup_cnt_o
  );
endinterface

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: line-aligns and deduplicates prefetches, squashes lines already
// covered by demand misses, and issues them to memory with a bounded outstanding count.
module prefetch_issue_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned MAX_OUTST  = 2
) (
  input logic                    clk,
  input logic                    rst,
  prefetch_issue_queue_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [31:0] LineMask = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [PtrW:0] OccFull = (PtrW + 1)'(DEPTH);
  localparam logic [3:0] OutstMax = 4'(MAX_OUTST);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [PtrW:0]     occ_q, occ_d;
  logic [3:0]        outst_q, outst_d;
  logic [15:0]       drop_q, drop_d, dup_q, dup_d;

  logic [31:0]       pf_line, dmd_line;
  logic [DEPTH-1:0]  pf_hit, squash;
  logic              presented, dmd_dup, q_dup, full;
  logic              push, pop, handshake, resp_dec, can_issue;

  assign pf_line   = bus.pf_addr_i & LineMask;
  assign dmd_line  = bus.dmd_addr_i & LineMask;
  assign presented = (state_q == StReq);

  // Valid bits are cleared on pop, so a set bit always marks an occupied slot.
  always_comb begin
    pf_hit = '0;
    squash = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pf_hit[i] = vld_q[i] && (addr_q[i] == pf_line);
      squash[i] = bus.dmd_miss_i && vld_q[i] && (addr_q[i] == dmd_line) &&
                  !(presented && (head_q == PtrW'(i)));
    end
  end

  assign dmd_dup   = bus.pf_valid_i && bus.dmd_miss_i && (pf_line == dmd_line);
  assign q_dup     = bus.pf_valid_i && (|pf_hit);
  assign full      = (occ_q == OccFull);
  assign push      = bus.pf_valid_i && !dmd_dup && !q_dup && !full;
  assign handshake = presented && bus.mem_req_ready_i;
  assign pop       = handshake || ((state_q == StIdle) && (occ_q != '0) && !vld_q[head_q]);
  assign resp_dec  = bus.mem_resp_v_i && (outst_q != 4'd0);
  // A head squashed this cycle must not be promoted to REQ.
  assign can_issue = vld_q[head_q] && !squash[head_q] && (outst_q < OutstMax);

  always_comb begin
    vld_d = vld_q & ~squash;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (!push && pop) occ_d = occ_q - 1'b1;
  end

  always_comb begin
    outst_d = outst_q;
    if (handshake && !resp_dec)      outst_d = outst_q + 4'd1;
    else if (!handshake && resp_dec) outst_d = outst_q - 4'd1;
  end

  always_comb begin
    drop_d = drop_q;
    dup_d  = dup_q;
    if (bus.pf_valid_i) begin
      if (dmd_dup || q_dup) begin
        if (dup_q != 16'hFFFF) dup_d = dup_q + 16'd1;
      end else if (full) begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      dup_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      occ_q   <= occ_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      dup_q   <= dup_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  // Entry payload needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) addr_q[tail_q] <= pf_line;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (can_issue) state_d = StReq;
      StReq:  if (bus.mem_req_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_req_v_o    = 1'b0;
    bus.mem_req_addr_o = '0;
    if (state_q == StReq) begin
      bus.mem_req_v_o    = 1'b1;
      bus.mem_req_addr_o = addr_q[head_q];
    end
  end

  assign bus.outst_o    = outst_q;
  assign bus.drop_cnt_o = drop_q;
  assign bus.dup_cnt_o  = dup_q;

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed bench for prefetch_issue_queue: issue latency, dedup, outstanding limit,
// full drop, demand squash and mid-request reset.
module tb_prefetch_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passed = 0;

  prefetch_issue_queue_if bus ();

  prefetch_issue_queue #(
    .DEPTH      (4),
    .LINE_BYTES (64),
    .MAX_OUTST  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] a);
    bus.pf_valid_i = 1'b1;
    bus.pf_addr_i  = a;
    tick();
    bus.pf_valid_i = 1'b0;
  endtask

  initial begin
    bus.pf_addr_i       = '0;
    bus.pf_valid_i      = 1'b0;
    bus.dmd_miss_i      = 1'b0;
    bus.dmd_addr_i      = '0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i    = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // Reset state
    chk("rst_v", 32'(bus.mem_req_v_o), 32'd0);
    chk("rst_addr", bus.mem_req_addr_o, 32'd0);
    chk("rst_outst", 32'(bus.outst_o), 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt_o), 32'd0);
    chk("rst_dup", 32'(bus.dup_cnt_o), 32'd0);

    // 1: latency and alignment
    push(32'h1004);
    chk("t1_v_n1", 32'(bus.mem_req_v_o), 32'd0);
    tick();
    chk("t1_v_n2", 32'(bus.mem_req_v_o), 32'd1);
    chk("t1_addr", bus.mem_req_addr_o, 32'h1000);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    chk("t1_outst", 32'(bus.outst_o), 32'd1);
    chk("t1_v_done", 32'(bus.mem_req_v_o), 32'd0);

    // 2/3: duplicate drop and outstanding limit
    push(32'h2000);
    push(32'h2010);
    push(32'h2040);
    chk("t2_dup", 32'(bus.dup_cnt_o), 32'd1);
    chk("t2_head", bus.mem_req_addr_o, 32'h2000);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    chk("t3_outst2", 32'(bus.outst_o), 32'd2);
    tick();
    chk("t3_held", 32'(bus.mem_req_v_o), 32'd0);
    bus.mem_resp_v_i = 1'b1;
    tick();
    bus.mem_resp_v_i = 1'b0;
    chk("t3_resp", 32'(bus.outst_o), 32'd1);
    chk("t3_still_idle", 32'(bus.mem_req_v_o), 32'd0);
    tick();
    chk("t3_issue_v", 32'(bus.mem_req_v_o), 32'd1);
    chk("t3_issue_addr", bus.mem_req_addr_o, 32'h2040);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i = 1'b1;
    tick(); tick(); tick();
    bus.mem_resp_v_i = 1'b0;
    chk("t3_no_underflow", 32'(bus.outst_o), 32'd0);

    // 4: full queue drop while head handshakes
    push(32'h4000);
    push(32'h4040);
    push(32'h4080);
    push(32'h40C0);
    bus.mem_req_ready_i = 1'b1;
    push(32'h4100);
    bus.mem_req_ready_i = 1'b0;
    chk("t4_drop", 32'(bus.drop_cnt_o), 32'd1);
    chk("t4_dup_same", 32'(bus.dup_cnt_o), 32'd1);
    chk("t4_outst", 32'(bus.outst_o), 32'd1);
    tick();
    chk("t4_next_addr", bus.mem_req_addr_o, 32'h4040);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i = 1'b1;
    tick(); tick();
    bus.mem_resp_v_i = 1'b0;
    chk("t4_outst0", 32'(bus.outst_o), 32'd0);
    chk("t4_third_addr", bus.mem_req_addr_o, 32'h4080);
    bus.mem_req_ready_i = 1'b1;
    tick(); tick();
    chk("t4_fourth_addr", bus.mem_req_addr_o, 32'h40C0);
    tick();
    bus.mem_req_ready_i = 1'b0;
    tick();
    chk("t4_fifth_gone", 32'(bus.mem_req_v_o), 32'd0);
    bus.mem_resp_v_i = 1'b1;
    tick(); tick();
    bus.mem_resp_v_i = 1'b0;

    // 5: demand squash of a queued entry, presented head immune
    push(32'h5000);
    push(32'h3000);
    bus.dmd_miss_i = 1'b1;
    bus.dmd_addr_i = 32'h5010;
    tick();
    bus.dmd_addr_i = 32'h3020;
    tick();
    bus.dmd_addr_i = 32'h6030;
    push(32'h6000);
    bus.dmd_miss_i = 1'b0;
    push(32'h3000);
    chk("t5_dup", 32'(bus.dup_cnt_o), 32'd2);
    chk("t5_head_v", 32'(bus.mem_req_v_o), 32'd1);
    chk("t5_head_addr", bus.mem_req_addr_o, 32'h5000);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    tick();
    chk("t5_squashed_skip", 32'(bus.mem_req_v_o), 32'd0);
    tick();
    chk("t5_requeued_v", 32'(bus.mem_req_v_o), 32'd1);
    chk("t5_requeued_addr", bus.mem_req_addr_o, 32'h3000);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    chk("t5_outst", 32'(bus.outst_o), 32'd2);
    bus.mem_resp_v_i = 1'b1;
    tick(); tick();
    bus.mem_resp_v_i = 1'b0;

    // 6: reset during REQ with entries queued
    push(32'h7000);
    push(32'h7040);
    push(32'h7080);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    push(32'h70C0);
    chk("t6_req_v", 32'(bus.mem_req_v_o), 32'd1);
    chk("t6_req_addr", bus.mem_req_addr_o, 32'h7040);
    chk("t6_outst", 32'(bus.outst_o), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_v", 32'(bus.mem_req_v_o), 32'd0);
    chk("t6_addr", bus.mem_req_addr_o, 32'd0);
    chk("t6_outst0", 32'(bus.outst_o), 32'd0);
    chk("t6_drop0", 32'(bus.drop_cnt_o), 32'd0);
    chk("t6_dup0", 32'(bus.dup_cnt_o), 32'd0);
    tick();
    chk("t6_empty", 32'(bus.mem_req_v_o), 32'd0);
    push(32'h8000);
    chk("t6_lat1", 32'(bus.mem_req_v_o), 32'd0);
    tick();
    chk("t6_lat2", 32'(bus.mem_req_v_o), 32'd1);
    chk("t6_new_addr", bus.mem_req_addr_o, 32'h8000);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    tick(); tick();
    chk("t6_no_stale", 32'(bus.mem_req_v_o), 32'd0);
    chk("t6_outst1", 32'(bus.outst_o), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
